// File: rtl/rect_fill_engine.sv
// Rectangle draw engine for the VGA pixel port: raster-order fill or outline,
// clipped to the screen, with a stall on the downstream ready.
module rect_fill_engine #(
  parameter int unsigned COORD_W     = 11,
  parameter int unsigned COLOUR_W    = 3,
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned SCREEN_H    = 120,
  parameter int unsigned OFFSCREEN_X = 160
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [COORD_W-1:0]  load_x,
  input  logic [COORD_W-1:0]  load_y,
  input  logic [COORD_W-1:0]  load_width,
  input  logic [COORD_W-1:0]  load_height,
  input  logic [COLOUR_W-1:0] load_colour,
  input  logic                load_mode,
  input  logic                ready,
  output logic                plot,
  output logic [COORD_W-1:0]  send_x,
  output logic [COORD_W-1:0]  send_y,
  output logic [COLOUR_W-1:0] send_colour,
  output logic                busy,
  output logic                draw_done
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  localparam logic [COORD_W:0]   SW  = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0]   SH  = (COORD_W+1)'(SCREEN_H);
  localparam logic [COORD_W-1:0] OFX = COORD_W'(OFFSCREEN_X);

  state_t state, state_nxt;

  logic [COORD_W-1:0]  x0, y0, xe, ye, cur_x, cur_y;
  logic [COORD_W:0]    right_e, bot_e;
  logic [COLOUR_W-1:0] colour;
  logic                mode;

  logic [COORD_W:0] sum_x, sum_y, lim_x, lim_y;
  logic             empty, on_draw, border, advance, last_col, last;

  // Edge arithmetic is one bit wider so x0+w never wraps before clipping.
  always_comb begin
    sum_x = {1'b0, load_x} + {1'b0, load_width};
    sum_y = {1'b0, load_y} + {1'b0, load_height};
    lim_x = (sum_x < SW) ? sum_x : SW;
    lim_y = (sum_y < SH) ? sum_y : SH;
    empty = (load_width == '0) || (load_height == '0) ||
            ({1'b0, load_x} >= SW) || ({1'b0, load_y} >= SH);
  end

  always_comb begin
    on_draw     = (state == DRAW);
    border      = !mode || (cur_x == x0) || ({1'b0, cur_x} == right_e) ||
                  (cur_y == y0) || ({1'b0, cur_y} == bot_e);
    plot        = on_draw && border;
    send_x      = on_draw ? cur_x : OFX;
    send_y      = on_draw ? cur_y : '0;
    send_colour = colour;
    busy        = (state != IDLE);
    draw_done   = (state == DONE);
    advance     = on_draw && (ready || !border);
    last_col    = (cur_x == xe);
    last        = last_col && (cur_y == ye);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = empty ? DONE : DRAW;
      DRAW:    if (advance && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x0      <= '0;
      y0      <= '0;
      xe      <= '0;
      ye      <= '0;
      right_e <= '0;
      bot_e   <= '0;
      cur_x   <= '0;
      cur_y   <= '0;
      colour  <= '0;
      mode    <= 1'b0;
    end else if (state == IDLE && start) begin
      x0      <= load_x;
      y0      <= load_y;
      xe      <= COORD_W'(lim_x - 1'b1);
      ye      <= COORD_W'(lim_y - 1'b1);
      right_e <= sum_x - 1'b1;
      bot_e   <= sum_y - 1'b1;
      cur_x   <= load_x;
      cur_y   <= load_y;
      colour  <= load_colour;
      mode    <= load_mode;
    end else if (advance && !last) begin
      if (last_col) begin
        cur_x <= x0;
        cur_y <= cur_y + 1'b1;
      end else begin
        cur_x <= cur_x + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: per-cycle comparison against a pixel-list model
// plus literal expectations for each directed draw.
module tb_rect_fill_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] load_x = '0, load_y = '0, load_width = '0, load_height = '0;
  logic [2:0]  load_colour = '0;
  logic        load_mode = 1'b0;
  logic        ready = 1'b1;
  logic        plot, busy, draw_done;
  logic [10:0] send_x, send_y;
  logic [2:0]  send_colour;

  rect_fill_engine #(.COORD_W(11), .COLOUR_W(3), .SCREEN_W(160), .SCREEN_H(120),
                     .OFFSCREEN_X(160)) dut (
    .clock(clk), .reset(rst), .start(start),
    .load_x(load_x), .load_y(load_y), .load_width(load_width), .load_height(load_height),
    .load_colour(load_colour), .load_mode(load_mode), .ready(ready),
    .plot(plot), .send_x(send_x), .send_y(send_y), .send_colour(send_colour),
    .busy(busy), .draw_done(draw_done)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; bit p; } pix_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: on an accepted start, list every scanned position with its plot flag.
  pix_t mq[$];
  int   mphase = 0;   // 0 idle, 1 drawing, 2 done pulse
  int   mcol   = 0;

  function automatic void build(input int x, input int y, input int w, input int h, input bit md);
    int xe, ye;
    mq.delete();
    if (w == 0 || h == 0 || x >= 160 || y >= 120) return;
    xe = ((x + w < 160) ? x + w : 160) - 1;
    ye = ((y + h < 120) ? y + h : 120) - 1;
    for (int yy = y; yy <= ye; yy++)
      for (int xx = x; xx <= xe; xx++) begin
        pix_t p;
        p.x = xx;
        p.y = yy;
        p.p = !md || xx == x || xx == x + w - 1 || yy == y || yy == y + h - 1;
        mq.push_back(p);
      end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_plot", 32'(plot), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(draw_done), 0);
      chk("rst_x", 32'(send_x), 160);
      chk("rst_y", 32'(send_y), 0);
      chk("rst_colour", 32'(send_colour), 0);
      mphase = 0;
      mq.delete();
    end else begin
      case (mphase)
        0: begin
          chk("idle_busy", 32'(busy), 0);
          chk("idle_plot", 32'(plot), 0);
          chk("idle_done", 32'(draw_done), 0);
          chk("idle_x", 32'(send_x), 160);
          chk("idle_y", 32'(send_y), 0);
          if (start) begin
            build(int'(load_x), int'(load_y), int'(load_width), int'(load_height), load_mode);
            mcol = int'(load_colour);
            mphase = (mq.size() == 0) ? 2 : 1;
          end
        end
        1: begin
          chk("draw_busy", 32'(busy), 1);
          chk("draw_done_low", 32'(draw_done), 0);
          chk("draw_plot", 32'(plot), 32'(mq[0].p));
          chk("draw_x", 32'(send_x), mq[0].x);
          chk("draw_y", 32'(send_y), mq[0].y);
          if (mq[0].p) chk("draw_colour", 32'(send_colour), mcol);
          if (ready || !mq[0].p) void'(mq.pop_front());
          if (mq.size() == 0) mphase = 2;
        end
        default: begin
          chk("done_busy", 32'(busy), 1);
          chk("done_pulse", 32'(draw_done), 1);
          chk("done_plot", 32'(plot), 0);
          chk("done_x", 32'(send_x), 160);
          mphase = 0;
        end
      endcase
    end
  end

  pix_t acc_q[$];

  function automatic int acc_xy(input int i);
    if (i < 0 || i >= acc_q.size()) return -1;
    return acc_q[i].x * 1000 + acc_q[i].y;
  endfunction

  // Caller is positioned #1 after a rising edge; ready is low in cycles rlo..rhi.
  task automatic run(input int x, input int y, input int w, input int h, input int col,
                     input int md, input int rlo, input int rhi,
                     output int done_cyc, output int nacc);
    load_x = 11'(x); load_y = 11'(y); load_width = 11'(w); load_height = 11'(h);
    load_colour = 3'(col); load_mode = md[0];
    start = 1'b1; ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    done_cyc = -1; nacc = 0; acc_q.delete();
    for (int k = 1; k <= 200; k++) begin
      ready = !(k >= rlo && k <= rhi);
      @(negedge clk);
      if (plot && ready) begin
        pix_t p;
        p.x = int'(send_x); p.y = int'(send_y); p.p = 1'b1;
        acc_q.push_back(p);
        nacc++;
      end
      if (draw_done) done_cyc = k;
      @(posedge clk); #1;
      if (done_cyc != -1) break;
    end
    ready = 1'b1;
  endtask

  int dc, na;
  bit found;

  initial begin
    #1;
    chk("init_x", 32'(send_x), 160);
    chk("init_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    @(posedge clk); #1;

    // T1 fill (5,7) 2x2
    run(5, 7, 2, 2, 3, 0, 0, 0, dc, na);
    chk("t1_done_cycle", dc, 5);
    chk("t1_accepted", na, 4);
    chk("t1_first", acc_xy(0), 5007);
    chk("t1_last", acc_xy(3), 6008);

    // T2 stall in cycles 2-3
    run(5, 7, 2, 2, 4, 0, 2, 3, dc, na);
    chk("t2_done_cycle", dc, 7);
    chk("t2_accepted", na, 4);
    chk("t2_second", acc_xy(1), 6007);

    // T3 clipped fill at the bottom-right corner
    run(158, 119, 5, 3, 2, 0, 0, 0, dc, na);
    chk("t3_done_cycle", dc, 3);
    chk("t3_accepted", na, 2);
    chk("t3_last", acc_xy(1), 159119);

    // T4 outline 3x3
    run(0, 0, 3, 3, 7, 1, 0, 0, dc, na);
    chk("t4_done_cycle", dc, 10);
    chk("t4_accepted", na, 8);
    found = 0;
    for (int i = 0; i < acc_q.size(); i++)
      if (acc_q[i].x == 1 && acc_q[i].y == 1) found = 1;
    chk("t4_centre_absent", 32'(found), 0);

    // T5 empty regions
    run(10, 10, 0, 4, 1, 0, 0, 0, dc, na);
    chk("t5a_done_cycle", dc, 1);
    chk("t5a_accepted", na, 0);
    run(200, 10, 4, 4, 1, 0, 0, 0, dc, na);
    chk("t5b_done_cycle", dc, 1);
    chk("t5b_accepted", na, 0);

    // Width that would overflow COORD_W bits, clipped to the right edge
    run(100, 5, 2047, 1, 5, 0, 0, 0, dc, na);
    chk("wide_done_cycle", dc, 61);
    chk("wide_accepted", na, 60);
    chk("wide_last", acc_xy(59), 159005);

    // Clipped outline: right edge off-screen, so (159,1) is interior
    run(158, 0, 4, 3, 6, 1, 0, 0, dc, na);
    chk("clip_ol_done_cycle", dc, 7);
    chk("clip_ol_accepted", na, 5);

    // T6 full-screen fill, ignored start while busy, then reset mid-draw
    load_x = '0; load_y = '0; load_width = 11'd160; load_height = 11'd120;
    load_colour = 3'd5; load_mode = 1'b0;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    load_x = 11'd3; load_y = 11'd4; load_width = 11'd2; load_height = 11'd2;
    load_colour = 3'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("t6_busy_before_reset", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("t6_reset_plot", 32'(plot), 0);
    chk("t6_reset_busy", 32'(busy), 0);
    chk("t6_reset_done", 32'(draw_done), 0);
    chk("t6_reset_x", 32'(send_x), 160);
    chk("t6_reset_y", 32'(send_y), 0);
    chk("t6_reset_colour", 32'(send_colour), 0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    @(posedge clk); #1;
    run(5, 7, 2, 2, 6, 0, 0, 0, dc, na);
    chk("t6_after_done_cycle", dc, 5);
    chk("t6_after_accepted", na, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
